// File: rtl/captura_tecla.sv
// captura_tecla: keypad scan accumulator, debouncer and 4-entry key FIFO.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   enable        1 = accumulate scan samples, 0 = freeze accumulation and FSM
//   indice_boton  scanner sample: [5:3] column (bit 5 = error), [2:0] row (bit 2 = none)
//   scan_fin      pulse on the last column sample of each scan
//   tecla         key code at the FIFO head (last popped code while empty)
//   tecla_valid   FIFO non-empty
//   tecla_ready   consumer accepts tecla
//   err_scan      sticky scanner-error flag
//   err_overflow  sticky dropped-event flag
//   errores_clr   clears both sticky flags (a same-cycle set wins)
module captura_tecla #(
  parameter int unsigned DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [5:0] indice_boton,
  input  logic       scan_fin,
  output logic [3:0] tecla,
  output logic       tecla_valid,
  input  logic       tecla_ready,
  output logic       err_scan,
  output logic       err_overflow,
  input  logic       errores_clr
);

  localparam logic [3:0] DebCnt = 4'(DEB_SCANS);

  typedef enum logic [1:0] {StIdle, StCandidato, StPresionado, StLiberando} state_e;

  // Position is {column[1:0], row[1:0]}.
  function automatic logic [3:0] key_map(input logic [3:0] pos);
    logic [3:0] code;
    case (pos)
      4'b0000: code = 4'h1;  4'b0001: code = 4'h4;  4'b0010: code = 4'h7;  4'b0011: code = 4'hE;
      4'b0100: code = 4'h2;  4'b0101: code = 4'h5;  4'b0110: code = 4'h8;  4'b0111: code = 4'h0;
      4'b1000: code = 4'h3;  4'b1001: code = 4'h6;  4'b1010: code = 4'h9;  4'b1011: code = 4'hF;
      4'b1100: code = 4'hA;  4'b1101: code = 4'hB;  4'b1110: code = 4'hC;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  logic       sample_ok, sample_err;
  logic [3:0] sample_pos;

  assign sample_err = enable & indice_boton[5];
  assign sample_ok  = enable & ~indice_boton[5] & ~indice_boton[2];
  assign sample_pos = {indice_boton[4:3], indice_boton[1:0]};

  // Scan accumulator and registered scan result
  logic       acc_hit_q, acc_hit_d, acc_multi_q, acc_multi_d;
  logic [3:0] acc_pos_q, acc_pos_d;
  logic       res_valid_q, res_valid_d, res_key_q, res_key_d;
  logic [3:0] res_pos_q, res_pos_d;
  logic       hit_now, multi_now;
  logic [3:0] pos_now;

  always_comb begin
    hit_now     = acc_hit_q | sample_ok;
    multi_now   = acc_multi_q | (acc_hit_q & sample_ok);
    pos_now     = sample_ok ? sample_pos : acc_pos_q;
    acc_hit_d   = 1'b0;
    acc_multi_d = 1'b0;
    acc_pos_d   = 4'd0;
    res_valid_d = 1'b0;
    res_key_d   = res_key_q;
    res_pos_d   = res_pos_q;
    if (enable) begin
      if (scan_fin) begin
        // Result includes this cycle's sample; accumulator restarts empty.
        res_valid_d = 1'b1;
        res_key_d   = hit_now & ~multi_now;
        res_pos_d   = pos_now;
      end else begin
        acc_hit_d   = hit_now;
        acc_multi_d = multi_now;
        acc_pos_d   = pos_now;
      end
    end
  end

  // Debounce FSM
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, k_q, k_d, cnt_inc;
  logic       eval, push_fire, push_q;
  logic [3:0] push_code, push_code_q;

  assign eval    = res_valid_q & enable;
  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    if (eval) begin
      unique case (state_q)
        StIdle: begin
          if (res_key_q) begin
            k_d     = res_pos_q;
            cnt_d   = 4'd1;
            state_d = (DebCnt == 4'd1) ? StPresionado : StCandidato;
          end
        end
        StCandidato: begin
          if (!res_key_q) begin
            state_d = StIdle;
          end else if (res_pos_q == k_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DebCnt) state_d = StPresionado;
          end else begin
            k_d   = res_pos_q;
            cnt_d = 4'd1;
          end
        end
        StPresionado: begin
          if (!res_key_q) begin
            cnt_d   = 4'd1;
            state_d = (DebCnt == 4'd1) ? StIdle : StLiberando;
          end
        end
        StLiberando: begin
          if (res_key_q) begin
            state_d = StPresionado;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DebCnt) state_d = StIdle;
          end
        end
      endcase
    end
  end

  always_comb begin
    push_fire = 1'b0;
    push_code = key_map(res_pos_q);
    if (eval && res_key_q) begin
      unique case (state_q)
        StIdle:      push_fire = (DebCnt == 4'd1);
        StCandidato: push_fire = (res_pos_q == k_q) && (cnt_inc == DebCnt);
        default:     push_fire = 1'b0;
      endcase
    end
  end

  // Key FIFO
  logic [3:0] mem_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;
  logic [3:0] last_q;
  logic       full, pop, wr_en, ovf_set;

  assign tecla_valid = (count_q != 3'd0);
  assign full        = (count_q == 3'd4);
  assign pop         = tecla_valid & tecla_ready;
  assign wr_en       = push_q & (~full | pop);
  assign ovf_set     = push_q & full & ~pop;
  assign tecla       = tecla_valid ? mem_q[rd_ptr_q] : last_q;

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_hit_q    <= 1'b0;
      acc_multi_q  <= 1'b0;
      acc_pos_q    <= 4'd0;
      res_valid_q  <= 1'b0;
      res_key_q    <= 1'b0;
      res_pos_q    <= 4'd0;
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      k_q          <= 4'd0;
      push_q       <= 1'b0;
      push_code_q  <= 4'd0;
      for (int i = 0; i < 4; i++) mem_q[i] <= 4'd0;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      count_q      <= 3'd0;
      last_q       <= 4'd0;
      err_scan     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      acc_hit_q    <= acc_hit_d;
      acc_multi_q  <= acc_multi_d;
      acc_pos_q    <= acc_pos_d;
      res_valid_q  <= res_valid_d;
      res_key_q    <= res_key_d;
      res_pos_q    <= res_pos_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      push_q       <= push_fire;
      push_code_q  <= push_code;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_code_q;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q      <= count_d;
      err_scan     <= sample_err | (err_scan & ~errores_clr);
      err_overflow <= ovf_set | (err_overflow & ~errores_clr);
    end
  end

endmodule

// File: tb/tb_captura_tecla.sv
module tb_captura_tecla;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       reset, enable, scan_fin, tecla_ready, errores_clr;
  logic [5:0] indice_boton;
  logic [3:0] tecla;
  logic       tecla_valid, err_scan, err_overflow;

  always #5 clk = ~clk;

  captura_tecla #(.DEB_SCANS(DEB)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .indice_boton (indice_boton),
    .scan_fin     (scan_fin),
    .tecla        (tecla),
    .tecla_valid  (tecla_valid),
    .tecla_ready  (tecla_ready),
    .err_scan     (err_scan),
    .err_overflow (err_overflow),
    .errores_clr  (errores_clr)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 0;
  bit rand_clr = 0;
  int beats = 0;

  // Reference model: sample count per scan, result history as run lengths,
  // a "held" flag for the debounced key, and a queue for the FIFO.
  int         m_acc_n;
  logic [3:0] m_acc_pos;
  bit         m_res_pend;
  int         m_res;        // -1 = NONE, else col*4+row
  bit         m_held;
  int         m_run_key;
  int         m_run_len;
  bit         m_push_pend;
  logic [3:0] m_push_val;
  logic [3:0] m_q[$];
  logic [3:0] m_last;
  bit         m_err_scan, m_err_ovf;

  function automatic logic [3:0] ref_map(input int col, input int row);
    if (row == 3) begin
      if (col == 0) return 4'hE;
      if (col == 1) return 4'h0;
      if (col == 2) return 4'hF;
      return 4'hD;
    end
    if (col == 3) return 4'(10 + row);
    return 4'(row * 3 + col + 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int sz;
    bit pop, nxt_push, nxt_res_pend, ovf;
    logic [3:0] nxt_val;
    int nxt_res;
    if (reset) begin
      m_acc_n = 0; m_acc_pos = 0; m_res_pend = 0; m_res = -1;
      m_held = 0; m_run_key = -2; m_run_len = 0;
      m_push_pend = 0; m_push_val = 0; m_q.delete(); m_last = 0;
      m_err_scan = 0; m_err_ovf = 0;
      return;
    end
    sz = m_q.size();
    pop = (sz > 0) && tecla_ready;
    nxt_push = 0; nxt_val = 0; nxt_res_pend = 0; nxt_res = -1; ovf = 0;
    if (pop) m_last = m_q.pop_front();
    if (m_push_pend) begin
      if (sz == 4 && !pop) ovf = 1;
      else m_q.push_back(m_push_val);
    end
    m_err_ovf  = ovf | (m_err_ovf & !errores_clr);
    m_err_scan = (enable && indice_boton[5]) | (m_err_scan & !errores_clr);
    if (m_res_pend && enable) begin
      if (m_res == m_run_key) m_run_len++;
      else begin m_run_key = m_res; m_run_len = 1; end
      if (!m_held && m_res >= 0 && m_run_len == int'(DEB)) begin
        m_held = 1; nxt_push = 1; nxt_val = ref_map(m_res / 4, m_res % 4);
      end else if (m_held && m_res < 0 && m_run_len == int'(DEB)) begin
        m_held = 0;
      end
    end
    if (!enable) m_acc_n = 0;
    else begin
      if (!indice_boton[5] && !indice_boton[2]) begin
        m_acc_n++;
        m_acc_pos = {indice_boton[4:3], indice_boton[1:0]};
      end
      if (scan_fin) begin
        nxt_res_pend = 1;
        nxt_res = (m_acc_n == 1) ? int'(m_acc_pos) : -1;
        m_acc_n = 0;
      end
    end
    m_res_pend = nxt_res_pend; m_res = nxt_res;
    m_push_pend = nxt_push; m_push_val = nxt_val;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (checking) begin
      check("tecla_valid", tecla_valid, m_q.size() != 0);
      check("tecla", tecla, (m_q.size() != 0) ? m_q[0] : m_last);
      check("err_scan", err_scan, m_err_scan);
      check("err_overflow", err_overflow, m_err_ovf);
      if (tecla_valid === 1'b1 && tecla_ready === 1'b1) beats++;
    end
  end

  task automatic tick(input bit en, input logic [5:0] idx, input bit fin, input bit rdy,
                      input bit clr, input bit rst);
    enable = en; indice_boton = idx; scan_fin = fin;
    tecla_ready = rdy; errores_clr = clr; reset = rst;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // rdy_mode: 0/1 fixed ready, 2 random
  task automatic scan(input logic [15:0] mask, input int err_col, input int rdy_mode);
    for (int c = 0; c < 4; c++) begin
      logic [5:0] idx;
      bit rdy, clr;
      idx = {1'b0, 2'(c), 3'b100};
      for (int r = 3; r >= 0; r--) if (mask[c * 4 + r]) idx = {1'b0, 2'(c), 1'b0, 2'(r)};
      if (err_col == c) idx[5] = 1'b1;
      rdy = (rdy_mode == 2) ? 1'($urandom % 2) : (rdy_mode == 1);
      clr = rand_clr && ($urandom % 16 == 0);
      tick(1, idx, c == 3, rdy, clr, 0);
    end
  endtask

  task automatic press(input int pos, input int n, input int rdy_mode);
    logic [15:0] m;
    m = 16'd1 << pos;
    repeat (n) scan(m, -1, rdy_mode);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) tick(1, 6'b000100, 0, rdy, 0, 0);
  endtask

  task automatic disable_episode(input int rdy_mode);
    int m, k;
    bit rdy;
    rdy = (rdy_mode == 1);
    tick(1, 6'b000100, 0, rdy, 0, 0);
    m = $urandom % 3;
    k = 1 + $urandom % 5;
    repeat (m) tick(1, 6'($urandom), 0, rdy, 0, 0);
    repeat (k) tick(0, 6'($urandom), 1'($urandom % 2), rdy, 0, 0);
  endtask

  initial begin
    logic [3:0] exp_codes [4];
    int b0, key, len, rm;
    logic [15:0] mask;
    exp_codes[0] = 4'h1; exp_codes[1] = 4'h2; exp_codes[2] = 4'h3; exp_codes[3] = 4'hA;

    tick(0, 6'b000100, 0, 0, 0, 1);
    tick(0, 6'b000100, 0, 0, 0, 1);
    checking = 1;
    check("reset tecla", tecla, 4'h0);
    check("reset valid", tecla_valid, 1'b0);
    check("reset err_scan", err_scan, 1'b0);
    check("reset err_overflow", err_overflow, 1'b0);

    // Clean press r1c2 -> 6, two edges after the 4th scan_fin
    b0 = beats;
    press(9, 4, 1);
    check("press latency +1", tecla_valid, 1'b0);
    idle(1, 1);
    check("press latency +1b", tecla_valid, 1'b0);
    idle(1, 1);
    check("press latency +2", tecla_valid, 1'b1);
    check("press code", tecla, 4'h6);
    press(9, 3, 1);
    scan(16'h0, -1, 1); scan(16'h0, -1, 1); scan(16'h0, -1, 1); scan(16'h0, -1, 1);
    check("held single beat", beats - b0, 1);

    // Bounce r0c0
    press(0, 2, 0);
    scan(16'h0, -1, 0);
    press(0, 3, 0);
    idle(2, 0);
    check("bounce early", tecla_valid, 1'b0);
    press(0, 1, 0);
    idle(2, 0);
    check("bounce valid", tecla_valid, 1'b1);
    check("bounce code", tecla, 4'h1);
    repeat (4) scan(16'h0, -1, 0);
    idle(1, 1);
    idle(1, 0);
    check("bounce drained", tecla_valid, 1'b0);
    check("empty holds last", tecla, 4'h1);

    // Two keys in the same scan
    b0 = beats;
    repeat (6) scan(16'h0044, -1, 1);
    idle(2, 1);
    check("multi no push", beats - b0, 0);
    repeat (4) scan(16'h0, -1, 1);

    // Overflow: 1,2,3,A queued, fifth press (4) dropped
    for (int i = 0; i < 5; i++) begin
      press(i == 4 ? 1 : i * 4, 4, 0);
      repeat (4) scan(16'h0, -1, 0);
    end
    check("overflow flag", err_overflow, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("drain order", tecla, exp_codes[i]);
      idle(1, 1);
    end
    check("drained", tecla_valid, 1'b0);
    tick(1, 6'b000100, 0, 0, 1, 0);
    check("overflow clear", err_overflow, 1'b0);

    // Scanner error flag
    tick(1, 6'b100100, 0, 0, 0, 0);
    check("err_scan set", err_scan, 1'b1);
    idle(3, 0);
    check("err_scan sticky", err_scan, 1'b1);
    tick(1, 6'b100100, 0, 0, 1, 0);
    check("err_scan set wins", err_scan, 1'b1);
    tick(1, 6'b000100, 0, 0, 1, 0);
    check("err_scan cleared", err_scan, 1'b0);
    tick(0, 6'b100000, 0, 0, 0, 0);
    check("err_scan ignored disabled", err_scan, 1'b0);

    // Disable mid-debounce holds FSM progress
    press(0, 2, 0);
    idle(1, 0);
    tick(1, 6'b000000, 0, 0, 0, 0);
    repeat (5) tick(0, 6'b001000, 1, 0, 0, 0);
    press(0, 2, 0);
    idle(2, 0);
    check("disable hold valid", tecla_valid, 1'b1);
    check("disable hold code", tecla, 4'h1);
    repeat (4) scan(16'h0, -1, 0);
    idle(2, 1);

    // Reset during release with two queued keys
    press(5, 4, 0);
    repeat (4) scan(16'h0, -1, 0);
    press(10, 4, 0);
    idle(2, 0);
    check("two queued", tecla_valid, 1'b1);
    scan(16'h0, -1, 0);
    idle(1, 0);
    tick(1, 6'b000100, 0, 0, 0, 1);
    check("reset valid", tecla_valid, 1'b0);
    check("reset tecla", tecla, 4'h0);
    press(10, 3, 0);
    idle(2, 0);
    check("repress partial", tecla_valid, 1'b0);
    press(10, 1, 0);
    idle(2, 0);
    check("repress valid", tecla_valid, 1'b1);
    check("repress code", tecla, 4'h9);
    repeat (4) scan(16'h0, -1, 1);

    // Randomized phase
    rand_clr = 1;
    for (int s = 0; s < 60; s++) begin
      key = ($urandom % 3 == 0) ? -1 : int'($urandom % 16);
      len = 1 + int'($urandom % 6);
      rm  = int'($urandom % 3);
      for (int j = 0; j < len; j++) begin
        mask = (key < 0) ? 16'h0 : (16'd1 << key);
        if ($urandom % 8 == 0) mask = mask ^ (16'd1 << ($urandom % 16));
        scan(mask, ($urandom % 20 == 0) ? int'($urandom % 4) : -1, rm);
        if ($urandom % 25 == 0) disable_episode(rm);
        if ($urandom % 150 == 0) tick(0, 6'b000100, 0, 0, 0, 1);
      end
    end
    rand_clr = 0;
    idle(8, 1);

    checking = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
